// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the VC arbiter and its grant selector:
// the FSM state encoding and the destination-bit index used by demux_d.
package vc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Index of the bit in a data word that selects the destination FIFO.
  // demux_d uses the same expression, so both sides always agree on routing.
  function automatic int dest_bit(input int data_size, input int bit_select);
    return data_size - bit_select;
  endfunction

endpackage

// File: rtl/vc_arbiter_rr_select.sv
// Eligibility and grant selection between VC0 and VC1.
// VC0 normally wins. VC1 is forced through once VC0 has taken MAX_CONSEC
// grants in a row while VC1 was waiting.
module vc_rr_select
  import vc_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       vc0_dest,
  input  logic       vc1_dest,
  input  logic       d0_almost_full,
  input  logic       d1_almost_full,
  input  logic [3:0] consec_cnt,
  output logic       elig0,
  output logic       elig1,
  output logic       grant0,
  output logic       grant1
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_CONSEC);

  logic starve;

  // A VC is eligible when it holds a word and that word's destination has room.
  // Only one VC is granted; VC0 loses priority when VC1 has been starved.
  always_comb begin
    elig0  = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
    elig1  = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
    starve = (consec_cnt == CNT_MAX) && elig1;
    grant0 = elig0 && !starve;
    grant1 = elig1 && (!elig0 || starve);
  end

endmodule

// File: rtl/vc_arbiter.sv
// Sequencer feeding demux_d from the two virtual-channel FIFOs.
// Pops are issued combinationally; the popped word reaches demux_d one
// cycle later through a registered data/valid pair.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_SIZE  = 6,
  parameter int BIT_SELECT = 2,
  parameter int MAX_CONSEC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic [DATA_SIZE-1:0] data_demux_d,
  output logic                 valid_demux_d,
  output logic [1:0]           state,
  output logic                 idle
);

  localparam int         DEST_BIT = dest_bit(DATA_SIZE, BIT_SELECT);
  localparam logic [3:0] CNT_MAX  = 4'(MAX_CONSEC);

  state_t     cur_state;
  state_t     next_state;
  logic [3:0] consec_cnt;
  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;
  logic       pop_en;

  vc_rr_select #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_select (
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_dest       (vc0_data[DEST_BIT]),
    .vc1_dest       (vc1_data[DEST_BIT]),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .consec_cnt     (consec_cnt),
    .elig0          (elig0),
    .elig1          (elig1),
    .grant0         (grant0),
    .grant1         (grant1)
  );

  // State register; reset always returns to RESET regardless of init.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_RESET;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state decode; init pulls IDLE/ACTIVE back into INIT without a pop.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_RESET:  next_state = init ? ST_INIT : ST_IDLE;
      ST_INIT:   next_state = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)               next_state = ST_INIT;
        else if (elig0 || elig1) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                 next_state = ST_INIT;
        else if (!elig0 && !elig1) next_state = ST_IDLE;
      end
      default:   next_state = ST_RESET;
    endcase
  end

  // Mealy pops and status outputs; nothing is popped during reset or init.
  always_comb begin
    pop_en  = !reset && !init && ((cur_state == ST_IDLE) || (cur_state == ST_ACTIVE));
    pop_vc0 = pop_en && grant0;
    pop_vc1 = pop_en && grant1;
    idle    = !reset && (cur_state == ST_IDLE) && vc0_empty && vc1_empty;
    state   = cur_state;
  end

  // Starvation counter: counts VC0 wins while VC1 waits, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      consec_cnt <= 4'd0;
    end else if (pop_vc1 || !elig1) begin
      consec_cnt <= 4'd0;
    end else if (pop_vc0 && (consec_cnt < CNT_MAX)) begin
      consec_cnt <= consec_cnt + 4'd1;
    end
  end

  // Output register: the granted head word is presented to demux_d one cycle after the pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_demux_d  <= '0;
      valid_demux_d <= 1'b0;
    end else if (pop_vc0) begin
      data_demux_d  <= vc0_data;
      valid_demux_d <= 1'b1;
    end else if (pop_vc1) begin
      data_demux_d  <= vc1_data;
      valid_demux_d <= 1'b1;
    end else begin
      data_demux_d  <= '0;
      valid_demux_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: per-cycle vector table for pops,
// state and idle, plus a scoreboard queue for the registered output word.
module tb_vc_arbiter;

  localparam logic [1:0] S_RST = 2'd0;
  localparam logic [1:0] S_INI = 2'd1;
  localparam logic [1:0] S_IDL = 2'd2;
  localparam logic [1:0] S_ACT = 2'd3;

  typedef struct {
    logic       rst;
    logic       ini;
    logic       e0;
    logic       e1;
    logic [5:0] w0;
    logic [5:0] w1;
    logic       af0;
    logic       af1;
    logic       xp0;
    logic       xp1;
    logic [1:0] xst;
    logic       xidle;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       init;
  logic       vc0_empty;
  logic       vc1_empty;
  logic [5:0] vc0_data;
  logic [5:0] vc1_data;
  logic       d0_almost_full;
  logic       d1_almost_full;
  logic       pop_vc0;
  logic       pop_vc1;
  logic [5:0] data_demux_d;
  logic       valid_demux_d;
  logic [1:0] state;
  logic       idle;

  int         checks;
  int         errors;
  logic [5:0] exp_q[$];
  vec_t       vecs[$];

  vc_arbiter #(
    .DATA_SIZE (6),
    .BIT_SELECT(2),
    .MAX_CONSEC(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .data_demux_d   (data_demux_d),
    .valid_demux_d  (valid_demux_d),
    .state          (state),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic ini, input logic e0, input logic e1,
                              input logic [5:0] w0, input logic [5:0] w1,
                              input logic af0, input logic af1,
                              input logic xp0, input logic xp1,
                              input logic [1:0] xst, input logic xidle);
    vec_t v;
    v.rst = rst; v.ini = ini; v.e0 = e0; v.e1 = e1;
    v.w0 = w0; v.w1 = w1; v.af0 = af0; v.af1 = af1;
    v.xp0 = xp0; v.xp1 = xp1; v.xst = xst; v.xidle = xidle;
    return v;
  endfunction

  task automatic compare(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset          = v.rst;
    init           = v.ini;
    vc0_empty      = v.e0;
    vc1_empty      = v.e1;
    vc0_data       = v.w0;
    vc1_data       = v.w1;
    d0_almost_full = v.af0;
    d1_almost_full = v.af1;
  endtask

  // Check combinational outputs and the registered word, then record any new pop.
  task automatic checkOutput(input vec_t v, input int row);
    logic [5:0] w;
    #1;
    compare("pop_vc0", row, {7'd0, pop_vc0}, {7'd0, v.xp0});
    compare("pop_vc1", row, {7'd0, pop_vc1}, {7'd0, v.xp1});
    compare("state",   row, {6'd0, state},   {6'd0, v.xst});
    compare("idle",    row, {7'd0, idle},    {7'd0, v.xidle});
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      compare("valid", row, {7'd0, valid_demux_d}, 8'd1);
      compare("data",  row, {2'd0, data_demux_d},  {2'd0, w});
    end else begin
      compare("valid", row, {7'd0, valid_demux_d}, 8'd0);
      compare("data",  row, {2'd0, data_demux_d},  8'd0);
    end
    if (v.xp0) exp_q.push_back(v.w0);
    if (v.xp1) exp_q.push_back(v.w1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // reset held for three cycles, then IDLE with both VCs empty
    vecs.push_back(mk(1,0,1,1,6'h00,6'h00,0,0, 0,0,S_RST,0));
    vecs.push_back(mk(1,0,1,1,6'h00,6'h00,0,0, 0,0,S_RST,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_RST,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_IDL,1));
    // single VC0 word, dest 0
    vecs.push_back(mk(0,0,0,1,6'h05,6'h00,0,0, 1,0,S_IDL,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_ACT,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_IDL,1));
    // both eligible: four VC0 grants then one VC1 grant, twice
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(0,0,0,0,6'h05,6'h03,0,0,
                        (k % 5) != 4, (k % 5) == 4, (k == 0) ? S_IDL : S_ACT, 0));
    end
    // VC0 head blocked by d1_almost_full, VC1 passes it
    vecs.push_back(mk(0,0,0,0,6'h12,6'h03,0,1, 0,1,S_ACT,0));
    vecs.push_back(mk(0,0,0,0,6'h12,6'h03,0,1, 0,1,S_ACT,0));
    vecs.push_back(mk(0,0,0,1,6'h12,6'h00,0,0, 1,0,S_ACT,0));
    // both heads blocked: ACTIVE for one cycle, then IDLE
    vecs.push_back(mk(0,0,0,0,6'h12,6'h10,0,1, 0,0,S_ACT,0));
    vecs.push_back(mk(0,0,0,0,6'h12,6'h10,0,1, 0,0,S_IDL,0));
    // init while ACTIVE: in-flight word drains, no pops until back in IDLE
    vecs.push_back(mk(0,0,0,1,6'h05,6'h00,0,0, 1,0,S_IDL,0));
    vecs.push_back(mk(0,1,0,1,6'h05,6'h00,0,0, 0,0,S_ACT,0));
    vecs.push_back(mk(0,1,0,1,6'h05,6'h00,0,0, 0,0,S_INI,0));
    vecs.push_back(mk(0,0,0,1,6'h05,6'h00,0,0, 0,0,S_INI,0));
    vecs.push_back(mk(0,0,0,1,6'h05,6'h00,0,0, 1,0,S_IDL,0));
    // reset with a pop pending, then init+reset together
    vecs.push_back(mk(1,0,0,1,6'h05,6'h00,0,0, 0,0,S_ACT,0));
    vecs.push_back(mk(0,1,0,1,6'h05,6'h00,0,0, 0,0,S_RST,0));
    vecs.push_back(mk(1,1,0,1,6'h05,6'h00,0,0, 0,0,S_INI,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_RST,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_IDL,1));
    // VC0 head blocked by d0_almost_full, VC1 word goes to dest 1
    vecs.push_back(mk(0,0,0,0,6'h05,6'h12,1,0, 0,1,S_IDL,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_ACT,0));
    vecs.push_back(mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_IDL,1));

    reset = 1'b1; init = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    @(posedge clk);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // almost_full rising right after a pop: the registered word is still delivered
    $display("[TB] in-flight word under back-pressure");
    begin
      vec_t seq[3];
      seq[0] = mk(0,0,0,1,6'h05,6'h00,0,0, 1,0,S_IDL,0);
      seq[1] = mk(0,0,0,1,6'h05,6'h00,1,0, 0,0,S_ACT,0);
      seq[2] = mk(0,0,1,1,6'h00,6'h00,0,0, 0,0,S_IDL,1);
      for (int i = 0; i < 3; i++) begin
        applyStimulus(seq[i]);
        checkOutput(seq[i], 100 + i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
Sequencer for the destination-split path. It arbitrates between the two virtual-channel FIFOs (VC0, VC1) for the single shared input of demux_d, and issues pops only when the destination FIFO selected by the head word's dest bit has room. It sits between the VC FIFOs and demux_d and drives data_demux_d/valid_demux_d directly. It contains a RESET/INIT/IDLE/ACTIVE state machine and a starvation counter.

Parameters:
DATA_SIZE, 6, word width; must equal demux_d DATA_SIZE.
BIT_SELECT, 2, dest bit index = DATA_SIZE-BIT_SELECT; must equal demux_d BIT_SELECT.
MAX_CONSEC, 4, max consecutive VC0 grants while VC1 is eligible; range 1..15.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
init  in  1  config/hold request; while high, no pops are issued.
vc0_empty  in  1  VC0 FIFO empty.
vc1_empty  in  1  VC1 FIFO empty.
vc0_data  in  DATA_SIZE  VC0 head word (show-ahead, valid when !vc0_empty).
vc1_data  in  DATA_SIZE  VC1 head word (show-ahead).
d0_almost_full  in  1  dest-0 FIFO almost full.
d1_almost_full  in  1  dest-1 FIFO almost full.
pop_vc0  out  1  combinational pop to VC0 (consumed at the clock edge).
pop_vc1  out  1  combinational pop to VC1.
data_demux_d  out  DATA_SIZE  registered word to demux_d.
valid_demux_d  out  1  registered valid to demux_d.
state  out  2  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
idle  out  1  high in IDLE with both VCs empty.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- While reset=1 at an edge: state<=RESET, data_demux_d<=0, valid_demux_d<=0, consec_cnt<=0. pop_vc0/pop_vc1=0 and idle=0 whenever state is RESET or reset=1.
- Eligibility:
  - eligX = !vcX_empty && !(dest(vcX_data) ? d1_almost_full : d0_almost_full).
  - dest(w) = w[DATA_SIZE-BIT_SELECT].
- Grant priority: VC0 has fixed priority over VC1. The exception is consec_cnt==MAX_CONSEC && elig1, in which case VC1 is granted.
- Grant rules:
  - Exactly one pop per cycle, at most.
  - Pops occur only in IDLE or ACTIVE, with init=0 and reset=0.
  - Pop is Mealy: asserted in the same cycle the decision is made.
- Output register:
  - On a grant edge: data_demux_d <= granted head word, valid_demux_d <= 1.
  - Otherwise: data_demux_d <= 0, valid_demux_d <= 0.
  - Latency is 1 cycle from pop to valid.
- Starvation counter consec_cnt (4 bits):
  - +1 on a VC0 grant while elig1=1.
  - Cleared on a VC1 grant, or when elig1=0.
  - Saturates at MAX_CONSEC.
- Back-pressure: almost_full must leave at least 2 free slots, because one word may be in flight in the output register when almost_full rises. The arbiter does not cancel a word that is already registered.
- FSM transitions:
  - RESET -> INIT if init=1, else IDLE.
  - INIT: no pops. Stays in INIT while init=1, then goes to IDLE.
  - IDLE -> ACTIVE when elig0||elig1, with the pop issued in that same cycle.
  - ACTIVE -> IDLE when !elig0 && !elig1.
  - IDLE or ACTIVE -> INIT when init=1. No pop in that cycle; the word already registered still drains next cycle.
- Boundary cases:
  - Both VCs empty: no pops, idle=1.
  - Head blocked by almost_full while the other VC is eligible: grant the other VC (no head-of-line block across VCs).
  - Both VCs blocked: stay ACTIVE for that cycle, then go to IDLE.
  - Reset mid-burst: the next edge clears valid, and no pop is issued in the reset cycle.
  - Simultaneous init and reset: reset wins.

Decomposition:
- Shared package: state encodings (ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE) and the DEST_BIT index expression shared with demux_d.
- One natural sub-module, vc_rr_select: combinational eligibility plus grant logic (heads, empties, almost_fulls, consec_cnt -> grant0/grant1).
- The FSM, counter and output register stay in vc_arbiter.

Test Plan:
1. Reset held 3 cycles, init=0 -> state RESET, then IDLE; valid_demux_d=0, pops=0, idle=1 with both VCs empty.
2. VC0 holds 0x05 (dest bit4=0), VC1 empty -> pop_vc0=1 in cycle N; data_demux_d=0x05, valid=1 at N+1; state ACTIVE, then IDLE once VC0 is empty.
3. Both VCs continuously eligible, MAX_CONSEC=4 -> grant pattern VC0,VC0,VC0,VC0,VC1, repeating; consec_cnt returns to 0 after each VC1 grant.
4. VC0 head 0x12 (dest=1) with d1_almost_full=1, VC1 head 0x03 (dest=0) -> pop_vc1 only; VC0 is popped once d1_almost_full drops.
5. init raised while ACTIVE -> no pop next cycle, state INIT, in-flight word still emitted once; init drops -> IDLE, then pops resume.
6. reset asserted in the same cycle as a pop request -> no pop, and valid_demux_d=0 on the next edge.
